// File: rtl/dma_memoria_pkg.sv
// rtl/dma_memoria_pkg.sv - shared state encoding, mode constants and default widths for dma_memoria
package dma_memoria_pkg;

    localparam int LARGURA_DADO_PADRAO = 8;
    localparam int LARGURA_END_PADRAO  = 8;

    localparam logic MODO_COPIA    = 1'b0;
    localparam logic MODO_PREENCHE = 1'b1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ESCRITA = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/dma_memoria.sv
// rtl/dma_memoria.sv - block copy / block fill initiator driving the single-port data memory
module dma_memoria
    import dma_memoria_pkg::*;
#(
    parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
    parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    modo,
    input  logic [LARGURA_END-1:0]  origem,
    input  logic [LARGURA_END-1:0]  destino,
    input  logic [LARGURA_END-1:0]  tamanho,
    input  logic [LARGURA_DADO-1:0] valorPreenchimento,
    output logic                    ocupado,
    output logic                    concluido,
    output logic                    writeEnable,
    output logic [LARGURA_END-1:0]  endereco,
    output logic [LARGURA_DADO-1:0] dadoEntrada,
    input  logic [LARGURA_DADO-1:0] dadoSaida
);

    estado_t                 estado;
    estado_t                 estado_prox;
    logic [LARGURA_END-1:0]  i;
    logic [LARGURA_END-1:0]  i_prox;
    logic [LARGURA_DADO-1:0] buffer;
    logic                    modo_r;
    logic [LARGURA_END-1:0]  origem_r;
    logic [LARGURA_END-1:0]  destino_r;
    logic [LARGURA_END-1:0]  tamanho_r;
    logic [LARGURA_DADO-1:0] valor_r;
    logic                    escreve;

    assign i_prox = i + LARGURA_END'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= OCIOSO;
            i         <= '0;
            buffer    <= '0;
            modo_r    <= MODO_COPIA;
            origem_r  <= '0;
            destino_r <= '0;
            tamanho_r <= '0;
            valor_r   <= '0;
        end else begin
            estado <= estado_prox;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        modo_r    <= modo;
                        origem_r  <= origem;
                        destino_r <= destino;
                        tamanho_r <= tamanho;
                        valor_r   <= valorPreenchimento;
                        i         <= '0;
                    end
                end
                LEITURA: buffer <= dadoSaida;
                ESCRITA: i      <= i_prox;
                default: ;
            endcase
        end
    end

    always_comb begin
        estado_prox = estado;
        escreve     = 1'b0;
        endereco    = '0;
        dadoEntrada = '0;
        case (estado)
            OCIOSO: begin
                if (start) begin
                    if (tamanho == '0)
                        estado_prox = FIM;
                    else if (modo == MODO_PREENCHE)
                        estado_prox = ESCRITA;
                    else
                        estado_prox = LEITURA;
                end
            end
            LEITURA: begin
                endereco    = origem_r + i;
                estado_prox = ESCRITA;
            end
            ESCRITA: begin
                endereco    = destino_r + i;
                escreve     = 1'b1;
                dadoEntrada = (modo_r == MODO_PREENCHE) ? valor_r : buffer;
                // i_prox compares against the word count, so the last write is at i = tamanho-1
                if (i_prox == tamanho_r)
                    estado_prox = FIM;
                else if (modo_r == MODO_PREENCHE)
                    estado_prox = ESCRITA;
                else
                    estado_prox = LEITURA;
            end
            FIM: estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    // Gating by reset keeps the memory untouched on the edge that aborts a transfer
    assign writeEnable = escreve & ~reset;
    assign ocupado     = (estado != OCIOSO);
    assign concluido   = (estado == FIM);

endmodule

// File: tb/tb_dma_memoria.sv
// tb/tb_dma_memoria.sv - self-checking bench for dma_memoria against a behavioural memory and reference model
module tb_dma_memoria;
    import dma_memoria_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       modo;
    logic [7:0] origem;
    logic [7:0] destino;
    logic [7:0] tamanho;
    logic [7:0] valorPreenchimento;
    logic       ocupado;
    logic       concluido;
    logic       writeEnable;
    logic [7:0] endereco;
    logic [7:0] dadoEntrada;
    logic [7:0] dadoSaida;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_memoria #(.LARGURA_DADO(8), .LARGURA_END(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .modo               (modo),
        .origem             (origem),
        .destino            (destino),
        .tamanho            (tamanho),
        .valorPreenchimento (valorPreenchimento),
        .ocupado            (ocupado),
        .concluido          (concluido),
        .writeEnable        (writeEnable),
        .endereco           (endereco),
        .dadoEntrada        (dadoEntrada),
        .dadoSaida          (dadoSaida)
    );

    assign dadoSaida = mem[endereco];

    always @(posedge clk) begin
        if (writeEnable)
            mem[endereco] <= dadoEntrada;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic ref_op(input logic m, input logic [7:0] src, input logic [7:0] dst,
                          input int n, input logic [7:0] val);
        for (int k = 0; k < n; k++) begin
            logic [7:0] a_dst;
            logic [7:0] a_src;
            a_dst = dst + 8'(k);
            a_src = src + 8'(k);
            ref_mem[a_dst] = (m == MODO_PREENCHE) ? val : ref_mem[a_src];
        end
    endtask

    task automatic compare_mem(input string tag);
        for (int k = 0; k < 256; k++)
            check($sformatf("%s mem[%0h]", tag, k), {24'd0, mem[k]}, {24'd0, ref_mem[k]});
    endtask

    task automatic run_op(input string tag, input logic m, input logic [7:0] src,
                          input logic [7:0] dst, input logic [7:0] n, input logic [7:0] val);
        int fim_cycle;
        int nwe;
        int exp_fim;
        logic we_exp;
        logic [7:0] a_exp;
        fim_cycle = 0;
        nwe       = 0;
        exp_fim   = (n == 0) ? 1 : ((m == MODO_PREENCHE) ? int'(n) : 2 * int'(n)) + 1;
        @(negedge clk);
        modo = m; origem = src; destino = dst; tamanho = n; valorPreenchimento = val;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            check({tag, " ocupado"}, {31'd0, ocupado}, 32'd1);
            if (n == 0)
                we_exp = 1'b0;
            else if (m == MODO_PREENCHE)
                we_exp = (c <= int'(n));
            else
                we_exp = (c <= 2 * int'(n)) && (c % 2 == 0);
            check({tag, " writeEnable"}, {31'd0, writeEnable}, {31'd0, we_exp});
            if (we_exp) begin
                a_exp = dst + ((m == MODO_PREENCHE) ? 8'(c - 1) : 8'(c / 2 - 1));
                check({tag, " endereco"}, {24'd0, endereco}, {24'd0, a_exp});
                if (m == MODO_PREENCHE)
                    check({tag, " dadoEntrada"}, {24'd0, dadoEntrada}, {24'd0, val});
            end
            if (writeEnable) nwe++;
            if (concluido) begin
                fim_cycle = c;
                break;
            end
            // A second start and scrambled inputs mid-transfer must be ignored
            if (c == 1) begin
                start = 1'b1;
                modo = 1'($urandom); origem = 8'($urandom); destino = 8'($urandom);
                tamanho = 8'($urandom); valorPreenchimento = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " concluido cycle"}, fim_cycle, exp_fim);
        check({tag, " write count"}, nwe, {24'd0, n});
        @(posedge clk); #1;
        check({tag, " ocupado after"}, {31'd0, ocupado}, 32'd0);
        check({tag, " concluido after"}, {31'd0, concluido}, 32'd0);
        check({tag, " endereco idle"}, {24'd0, endereco}, 32'd0);
        ref_op(m, src, dst, int'(n), val);
        compare_mem(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; modo = 1'b0; origem = '0; destino = '0;
        tamanho = '0; valorPreenchimento = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset ocupado", {31'd0, ocupado}, 32'd0);
        check("reset concluido", {31'd0, concluido}, 32'd0);
        check("reset writeEnable", {31'd0, writeEnable}, 32'd0);
        check("reset endereco", {24'd0, endereco}, 32'd0);
        check("reset dadoEntrada", {24'd0, dadoEntrada}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 8'(k); pre_data = 8'($urandom);
            ref_mem[k] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;

        run_op("fill", MODO_PREENCHE, 8'h00, 8'h10, 8'd4, 8'hA5);

        preload(8'h20, 8'd11); preload(8'h21, 8'd22); preload(8'h22, 8'd33);
        run_op("copy", MODO_COPIA, 8'h20, 8'h40, 8'd3, 8'h00);
        check("copy mem40", {24'd0, mem[8'h40]}, 32'd11);
        check("copy mem42", {24'd0, mem[8'h42]}, 32'd33);

        run_op("wrap", MODO_PREENCHE, 8'h00, 8'hFE, 8'd3, 8'h5C);
        check("wrap mem00", {24'd0, mem[8'h00]}, 32'h5C);

        run_op("zero", MODO_COPIA, 8'h50, 8'h60, 8'd0, 8'hFF);

        preload(8'h30, 8'd7); preload(8'h31, 8'd9);
        run_op("overlap", MODO_COPIA, 8'h30, 8'h31, 8'd2, 8'h00);
        check("overlap mem32", {24'd0, mem[8'h32]}, 32'd7);

        @(negedge clk);
        modo = MODO_PREENCHE; destino = 8'h80; tamanho = 8'd8; valorPreenchimento = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check("rst fill writeEnable", {31'd0, writeEnable}, 32'd1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("rst gated writeEnable", {31'd0, writeEnable}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst ocupado", {31'd0, ocupado}, 32'd0);
        check("rst concluido", {31'd0, concluido}, 32'd0);
        ref_op(MODO_PREENCHE, 8'h00, 8'h80, 3, 8'h3C);
        compare_mem("rst");

        run_op("after rst", MODO_COPIA, 8'h80, 8'h90, 8'd5, 8'h00);

        for (int r = 0; r < 20; r++)
            run_op($sformatf("rand%0d", r), 1'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom_range(0, 24)), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
